bias_add_stage: RTL and testbench
=================================

Name: bias_add_stage

Overview:
- Downstream consumer of the bias buffer. Fetches one 512-bit bias vector per output-channel group over the buffer's read port, then holds it.
- Adds the held vector lane-wise to every accumulator vector of that group, with optional ReLU and signed saturation, and emits the result to the requantize/writeback stage.
- Sequenced by a start/done command from the layer controller.

Parameters:
- LANES, 16, number of parallel channel lanes per vector.
- DATA_W, 32, width of one accumulator lane and one bias lane (LANES*DATA_W = 512).
- ADDR_W, 8, bias buffer address width.
- CNT_W, 16, width of the group and pixel counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle command pulse; honoured only in IDLE.
- i_bias_base  in  ADDR_W  bias buffer address of group 0.
- i_num_groups  in  CNT_W  number of output-channel groups.
- i_pix_per_group  in  CNT_W  accumulator vectors per group.
- i_relu_en  in  1  clamp negative results to 0.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_bias_rd_en  out  1  bias buffer read enable.
- o_bias_raddr  out  ADDR_W  bias buffer read address.
- i_bias_data  in  LANES*DATA_W  bias read data.
- i_bias_data_vld  in  1  bias data valid; arrives one cycle after o_bias_rd_en.
- i_acc_data  in  LANES*DATA_W  accumulator vector; lane k = bits [k*DATA_W +: DATA_W], signed.
- i_acc_vld  in  1  accumulator valid.
- o_acc_rdy  out  1  accumulator ready.
- o_out_data  out  LANES*DATA_W  biased result, same lane packing.
- o_out_vld  out  1  result valid.
- i_out_rdy  in  1  downstream ready.

Behaviour:
- Reset (rst=0 at posedge): FSM to IDLE; counters, bias register and o_out_data cleared to 0; o_busy, o_done, o_bias_rd_en, o_acc_rdy and o_out_vld all 0; o_bias_raddr = 0. Reset mid-operation aborts immediately with no o_done.
- Command capture: on i_start in IDLE, latch i_bias_base, i_num_groups, i_pix_per_group and i_relu_en; clear grp_cnt and pix_cnt.
  - If either count is 0, go to DONE.
  - Otherwise go to FETCH.
  - i_start outside IDLE is ignored.
- FETCH: o_bias_rd_en=1 for exactly one cycle, with o_bias_raddr = i_bias_base + grp_cnt (modulo 2^ADDR_W, wraps). Next state WAIT.
- WAIT: when i_bias_data_vld=1, load the bias register and go to RUN. Stays in WAIT indefinitely if vld never arrives.
- RUN:
  - o_acc_rdy = !o_out_vld || i_out_rdy.
  - Accept = i_acc_vld && o_acc_rdy. On accept, o_out_data lane k = sat(acc_k + bias_k), then ReLU if enabled; o_out_vld=1 next cycle.
  - If o_out_vld && i_out_rdy with no accept, o_out_vld drops to 0.
  - The output register is a single stage, sustaining 1 vector/cycle when i_out_rdy=1.
- Arithmetic: each lane is computed as a 33-bit signed sum, saturated to [-2^31, 2^31-1]. ReLU is applied after saturation and maps negatives to 0.
- Counters (in RUN, on accept):
  - pix_cnt++ on each accept.
  - When pix_cnt == pix_per_group-1, clear pix_cnt and grp_cnt++.
  - Go to FETCH if more groups remain; go to DRAIN if that was the last group.
  - The held output register is not disturbed during the re-fetch. o_acc_rdy=0 outside RUN.
- DRAIN: wait until o_out_vld=0 or (o_out_vld && i_out_rdy), then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy is high in FETCH, WAIT, RUN, DRAIN and DONE.
- Backpressure: while o_out_vld=1 and i_out_rdy=0, o_out_data and o_out_vld hold stable and o_acc_rdy=0.

Test Plan:
- Basic add: base=5, groups=1, pix=3, bias lanes all 10, acc lanes 1,2,3 → one read at addr 5; outputs 11,12,13 in consecutive cycles; o_done exactly one cycle after the last output handshake.
- Multi-group with address wrap: base=254, groups=3, pix=2 → reads at addresses 254, 255, 0, each followed by exactly 2 outputs using that group's bias; total 6 outputs.
- Saturation/ReLU: bias=0x7FFFFFF0, acc=0x20 → 0x7FFFFFFF. Bias=0x80000000, acc=-1 → 0x80000000, which becomes 0 when relu_en=1. Bias=-5, acc=3 with relu_en=1 → 0.
- Backpressure: hold i_out_rdy=0 for 4 cycles mid-stream → o_out_data stable, o_acc_rdy=0, no vector lost or duplicated; order preserved after release.
- Degenerate/ignored commands: groups=0 → o_done pulses 2 cycles after i_start with no o_bias_rd_en. A second i_start while busy is ignored.
- Reset mid-RUN: drop rst after 1 of 4 outputs → all outputs 0 next cycle, no o_done; a fresh i_start runs correctly from group 0.

Source files
------------

// File: rtl/bias_add_stage.sv
// Bias-add stage: fetches one bias vector per output-channel group, then adds it
// lane-wise to each accumulator vector of the group with saturation and optional ReLU.
module bias_add_stage #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_bias_base,
  input  logic [CNT_W-1:0]          i_num_groups,
  input  logic [CNT_W-1:0]          i_pix_per_group,
  input  logic                      i_relu_en,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_bias_rd_en,
  output logic [ADDR_W-1:0]         o_bias_raddr,
  input  logic [LANES*DATA_W-1:0]   i_bias_data,
  input  logic                      i_bias_data_vld,
  input  logic [LANES*DATA_W-1:0]   i_acc_data,
  input  logic                      i_acc_vld,
  output logic                      o_acc_rdy,
  output logic [LANES*DATA_W-1:0]   o_out_data,
  output logic                      o_out_vld,
  input  logic                      i_out_rdy
);

  localparam int unsigned VEC_W = LANES * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    ngrp_q;
  logic [CNT_W-1:0]    npix_q;
  logic                relu_q;
  logic [CNT_W-1:0]    grp_q;
  logic [CNT_W-1:0]    pix_q;
  logic [VEC_W-1:0]    bias_q;
  logic [VEC_W-1:0]    out_data_q;
  logic                out_vld_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   raddr_q;

  logic [VEC_W-1:0]    result_d;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   lane;
  logic                acc_rdy;
  logic                accept;
  logic                last_pix;
  logic                last_grp;

  assign acc_rdy  = (state_q == S_RUN) && (!out_vld_q || i_out_rdy);
  assign accept   = acc_rdy && i_acc_vld;
  assign last_pix = (pix_q == npix_q - CNT_W'(1));
  assign last_grp = (grp_q == ngrp_q - CNT_W'(1));

  // Sign-extend to DATA_W+1 bits; the two top bits disagree exactly on overflow.
  always_comb begin
    result_d = '0;
    sum      = '0;
    lane     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum = {i_acc_data[k*DATA_W + DATA_W - 1], i_acc_data[k*DATA_W +: DATA_W]}
          + {bias_q[k*DATA_W + DATA_W - 1], bias_q[k*DATA_W +: DATA_W]};
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        lane = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        lane = sum[DATA_W-1:0];
      end
      if (relu_q && lane[DATA_W-1]) begin
        lane = '0;
      end
      result_d[k*DATA_W +: DATA_W] = lane;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      ngrp_q     <= '0;
      npix_q     <= '0;
      relu_q     <= 1'b0;
      grp_q      <= '0;
      pix_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      raddr_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;

      // Output register is shared by all states so a held vector drains during re-fetch.
      if (accept) begin
        out_data_q <= result_d;
        out_vld_q  <= 1'b1;
      end else if (out_vld_q && i_out_rdy) begin
        out_vld_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            base_q <= i_bias_base;
            ngrp_q <= i_num_groups;
            npix_q <= i_pix_per_group;
            relu_q <= i_relu_en;
            grp_q  <= '0;
            pix_q  <= '0;
            busy_q <= 1'b1;
            if (i_num_groups == '0 || i_pix_per_group == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
              raddr_q <= i_bias_base;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_bias_data_vld) begin
            bias_q  <= i_bias_data;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_pix) begin
              pix_q <= '0;
              grp_q <= grp_q + CNT_W'(1);
              if (last_grp) begin
                state_q <= S_DRAIN;
              end else begin
                state_q <= S_FETCH;
                rd_en_q <= 1'b1;
                raddr_q <= base_q + ADDR_W'(grp_q + CNT_W'(1));
              end
            end else begin
              pix_q <= pix_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!out_vld_q || i_out_rdy) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_bias_rd_en = rd_en_q;
  assign o_bias_raddr = raddr_q;
  assign o_acc_rdy    = acc_rdy;
  assign o_out_data   = out_data_q;
  assign o_out_vld    = out_vld_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Self-checking bench for bias_add_stage: randomized vectors against a
// lane-wise integer reference model of bias add, saturation and ReLU.
module tb_bias_add_stage;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [7:0]    i_bias_base;
  logic [15:0]   i_num_groups;
  logic [15:0]   i_pix_per_group;
  logic          i_relu_en;
  logic          o_busy, o_done, o_bias_rd_en;
  logic [7:0]    o_bias_raddr;
  logic [VW-1:0] i_bias_data;
  logic          i_bias_data_vld;
  logic [VW-1:0] i_acc_data;
  logic          i_acc_vld;
  logic          o_acc_rdy;
  logic [VW-1:0] o_out_data;
  logic          o_out_vld;
  logic          i_out_rdy;

  bias_add_stage #(.LANES(LANES), .DATA_W(DW), .ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_bias_base(i_bias_base),
    .i_num_groups(i_num_groups), .i_pix_per_group(i_pix_per_group),
    .i_relu_en(i_relu_en), .o_busy(o_busy), .o_done(o_done),
    .o_bias_rd_en(o_bias_rd_en), .o_bias_raddr(o_bias_raddr),
    .i_bias_data(i_bias_data), .i_bias_data_vld(i_bias_data_vld),
    .i_acc_data(i_acc_data), .i_acc_vld(i_acc_vld), .o_acc_rdy(o_acc_rdy),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit run_finished;

  logic [VW-1:0] mem [256];
  logic [VW-1:0] acc_q [$];
  logic [VW-1:0] out_q [$];
  logic [VW-1:0] exp_q [$];
  int            out_cyc [$];
  int            rd_q [$];

  always @(posedge clk) cyc++;

  // Bias buffer: registered read, data valid one cycle after the read enable.
  always @(posedge clk) begin
    i_bias_data_vld <= o_bias_rd_en;
    i_bias_data     <= mem[o_bias_raddr];
  end

  always @(negedge clk) begin
    if (rst) begin
      if (o_out_vld && i_out_rdy) begin
        out_q.push_back(o_out_data);
        out_cyc.push_back(cyc);
      end
      if (o_bias_rd_en) rd_q.push_back(int'(o_bias_raddr));
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] acc,
                                              input logic [VW-1:0] bias, input bit relu);
    logic [VW-1:0] r;
    int     ai, bi;
    longint s;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      ai = acc[k*DW +: DW];
      bi = bias[k*DW +: DW];
      s  = longint'(ai) + longint'(bi);
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (relu && s < 0) s = 0;
      r[k*DW +: DW] = s[31:0];
    end
    return r;
  endfunction

  function automatic void build_expected(input int base, input int ng, input int np, input bit relu);
    int idx = 0;
    exp_q.delete();
    for (int g = 0; g < ng; g++)
      for (int p = 0; p < np; p++) begin
        exp_q.push_back(model_vec(acc_q[idx], mem[(base + g) % 256], relu));
        idx++;
      end
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int unsigned   r;
    for (int k = 0; k < LANES; k++) begin
      r = $urandom_range(0, 7);
      v[k*DW +: DW] = (r == 0) ? 32'h7FFF_FFFF : (r == 1) ? 32'h8000_0000 : 32'($urandom);
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [31:0] x);
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = x;
    return v;
  endfunction

  task automatic start_cmd(input int base, input int ng, input int np, input bit relu);
    @(posedge clk); #1;
    out_q.delete(); out_cyc.delete(); rd_q.delete();
    i_bias_base = 8'(base); i_num_groups = 16'(ng); i_pix_per_group = 16'(np);
    i_relu_en = relu; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed_all();
    bit stalled = 0;
    foreach (acc_q[i]) begin
      bit acc = 0;
      int t = 0;
      i_acc_data = acc_q[i];
      i_acc_vld  = 1'b1;
      while (!acc && t < 500) begin
        @(negedge clk);
        acc = o_acc_rdy;
        t++;
        @(posedge clk); #1;
      end
      if (!acc) begin stalled = 1; break; end
    end
    i_acc_vld = 1'b0;
    n_assert++;
    if (stalled) begin n_fail++; $display("FAIL feed_stall: accumulator vector never accepted"); end
  endtask

  task automatic rdy_driver(input int mode);
    while (!run_finished) begin
      @(posedge clk); #1;
      i_out_rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    i_out_rdy = 1'b1;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin @(negedge clk); t++; end
    run_finished = 1;
    n_assert++;
    if (done_cnt == d0) begin n_fail++; $display("FAIL done_timeout: got no o_done, expected one"); end
  endtask

  task automatic spur_start(input bit en);
    if (en) begin
      repeat (6) @(posedge clk);
      #1;
      i_start = 1'b1; i_bias_base = 8'h11; i_num_groups = 16'd7; i_pix_per_group = 16'd1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
  endtask

  task automatic run_cmd(input int base, input int ng, input int np, input bit relu,
                         input int mode, input bit spur);
    int d0 = done_cnt;
    run_finished = 0;
    start_cmd(base, ng, np, relu);
    fork
      feed_all();
      rdy_driver(mode);
      wait_done(d0);
      spur_start(spur);
    join
  endtask

  task automatic test_reset();
    rst = 1'b0; i_start = 0; i_acc_vld = 0; i_out_rdy = 1; i_relu_en = 0;
    i_bias_base = 0; i_num_groups = 0; i_pix_per_group = 0; i_acc_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({o_busy, o_done, o_bias_rd_en, o_acc_rdy, o_out_vld} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {o_busy, o_done, o_bias_rd_en, o_acc_rdy, o_out_vld});
    end
    n_assert++;
    if (o_bias_raddr !== 8'h00 || o_out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: raddr %h data %h expected 0", o_bias_raddr, o_out_data);
    end
  endtask

  task automatic test_basic();
    mem[5] = splat(32'd10);
    acc_q.delete();
    for (int i = 0; i < 3; i++) acc_q.push_back(splat(32'(i + 1)));
    run_cmd(5, 1, 3, 0, 0, 0);
    build_expected(5, 1, 3, 0);
    n_assert++;
    if (rd_q.size() != 1 || rd_q[0] != 5) begin
      n_fail++; $display("FAIL basic_reads: got %p expected '{5}", rd_q);
    end
    n_assert++;
    if (out_q.size() != 3) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 3", out_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [VW-1:0] ev;
        ev = splat(32'(i + 11));
        n_assert++;
        if (out_q[i] !== ev || out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL basic_out%0d: got %h expected %h", i, out_q[i], ev);
        end
        n_assert++;
        if (out_cyc[i] != out_cyc[0] + i) begin
          n_fail++; $display("FAIL basic_consec%0d: got cycle %0d expected %0d", i, out_cyc[i], out_cyc[0] + i);
        end
      end
      n_assert++;
      if (done_cyc != out_cyc[2] + 1) begin
        n_fail++; $display("FAIL basic_done_time: got cycle %0d expected %0d", done_cyc, out_cyc[2] + 1);
      end
    end
  endtask

  task automatic test_multigroup_wrap();
    int d0;
    mem[254] = rand_vec(); mem[255] = rand_vec(); mem[0] = rand_vec();
    acc_q.delete();
    for (int i = 0; i < 6; i++) acc_q.push_back(rand_vec());
    d0 = done_cnt;
    run_cmd(254, 3, 2, 0, 0, 1);
    build_expected(254, 3, 2, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (rd_q.size() != 3 || rd_q[0] != 254 || rd_q[1] != 255 || rd_q[2] != 0) begin
      n_fail++; $display("FAIL multi_reads: got %p expected '{254, 255, 0}", rd_q);
    end
    n_assert++;
    if (done_cnt != d0 + 1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL multi_spurious: got %0d dones busy=%b expected 1 done busy=0", done_cnt - d0, o_busy);
    end
    n_assert++;
    if (out_q.size() != 6) begin
      n_fail++; $display("FAIL multi_count: got %0d expected 6", out_q.size());
    end else
      for (int i = 0; i < 6; i++) begin
        n_assert++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL multi_out%0d: got %h expected %h", i, out_q[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] b, a;
    logic [31:0] exp0 [2], exp1 [2], exp2 [2];
    exp0[0] = 32'h7FFF_FFFF; exp1[0] = 32'h8000_0000; exp2[0] = 32'hFFFF_FFFE;
    exp0[1] = 32'h7FFF_FFFF; exp1[1] = 32'h0000_0000; exp2[1] = 32'h0000_0000;
    b = rand_vec(); a = rand_vec();
    b[31:0] = 32'h7FFF_FFF0;  a[31:0] = 32'h0000_0020;
    b[63:32] = 32'h8000_0000; a[63:32] = 32'hFFFF_FFFF;
    b[95:64] = 32'hFFFF_FFFB; a[95:64] = 32'h0000_0003;
    mem[40] = b;
    for (int r = 0; r < 2; r++) begin
      acc_q.delete();
      acc_q.push_back(a);
      run_cmd(40, 1, 1, r[0], 0, 0);
      build_expected(40, 1, 1, r[0]);
      n_assert++;
      if (out_q.size() != 1) begin
        n_fail++; $display("FAIL sat_count relu=%0d: got %0d expected 1", r, out_q.size());
      end else begin
        n_assert++;
        if (out_q[0][31:0] !== exp0[r] || out_q[0][63:32] !== exp1[r] || out_q[0][95:64] !== exp2[r]) begin
          n_fail++; $display("FAIL sat_lanes relu=%0d: got %h %h %h expected %h %h %h", r,
                             out_q[0][31:0], out_q[0][63:32], out_q[0][95:64], exp0[r], exp1[r], exp2[r]);
        end
        n_assert++;
        if (out_q[0] !== exp_q[0]) begin
          n_fail++; $display("FAIL sat_vec relu=%0d: got %h expected %h", r, out_q[0], exp_q[0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int d0;
    bit timed_out;
    logic [VW-1:0] held;
    mem[77] = rand_vec();
    acc_q.delete();
    for (int i = 0; i < 8; i++) acc_q.push_back(rand_vec());
    d0 = done_cnt;
    run_finished = 0;
    start_cmd(77, 1, 8, 1);
    fork
      feed_all();
      begin
        int t = 0;
        while (out_q.size() < 3 && t < 200) begin @(negedge clk); t++; end
        timed_out = (out_q.size() < 3);
        @(posedge clk); #1;
        i_out_rdy = 1'b0;
        @(negedge clk);
        held = o_out_data;
        n_assert++;
        if (timed_out || o_out_vld !== 1'b1) begin
          n_fail++; $display("FAIL bp_vld: got vld=%b timeout=%0d expected vld=1", o_out_vld, timed_out);
        end
        for (int c = 0; c < 4; c++) begin
          if (c > 0) @(negedge clk);
          n_assert++;
          if (o_out_data !== held || o_out_vld !== 1'b1 || o_acc_rdy !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold%0d: vld=%b rdy=%b data %h expected vld=1 rdy=0 data %h",
                               c, o_out_vld, o_acc_rdy, o_out_data, held);
          end
        end
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
      end
      wait_done(d0);
    join
    build_expected(77, 1, 8, 1);
    n_assert++;
    if (out_q.size() != 8) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 8", out_q.size());
    end else
      for (int i = 0; i < 8; i++) begin
        n_assert++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL bp_out%0d: got %h expected %h", i, out_q[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_degenerate();
    for (int r = 0; r < 2; r++) begin
      int d0 = done_cnt;
      int t  = 0;
      start_cmd(9, (r == 0) ? 0 : 2, (r == 0) ? 4 : 0, 0);
      while (done_cnt == d0 && t < 3) begin @(negedge clk); t++; end
      repeat (4) @(negedge clk);
      n_assert++;
      if (done_cnt != d0 + 1 || t > 2 || rd_q.size() != 0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL degen%0d: dones=%0d delay=%0d reads=%0d busy=%b expected 1 <=2 0 0",
                           r, done_cnt - d0, t, rd_q.size(), o_busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int d0, t;
    mem[3] = rand_vec();
    acc_q.delete();
    d0 = done_cnt;
    start_cmd(3, 1, 4, 0);
    i_acc_data = rand_vec(); i_acc_vld = 1'b1;
    t = 0;
    while (out_q.size() < 1 && t < 100) begin
      @(negedge clk);
      t++;
      @(posedge clk); #1;
      if (o_out_vld) i_acc_vld = 1'b0;
    end
    i_acc_vld = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (out_q.size() != 1 || {o_busy, o_done, o_bias_rd_en, o_acc_rdy, o_out_vld} !== 5'b0 || o_out_data !== '0) begin
      n_fail++; $display("FAIL midreset_clear: outs=%0d flags=%b data %h expected 1 00000 0", out_q.size(),
                         {o_busy, o_done, o_bias_rd_en, o_acc_rdy, o_out_vld}, o_out_data);
    end
    repeat (3) @(negedge clk);
    n_assert++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL midreset_nodone: got %0d dones expected 0", done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) acc_q.push_back(rand_vec());
    run_cmd(3, 1, 4, 0, 0, 0);
    build_expected(3, 1, 4, 0);
    n_assert++;
    if (out_q.size() != 4 || rd_q.size() != 1 || rd_q[0] != 3) begin
      n_fail++; $display("FAIL midreset_rerun: outs=%0d reads=%p expected 4 '{3}", out_q.size(), rd_q);
    end else
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL midreset_out%0d: got %h expected %h", i, out_q[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int base = $urandom_range(0, 255);
      int ng   = $urandom_range(1, 3);
      int np   = $urandom_range(1, 4);
      bit relu = 1'($urandom_range(0, 1));
      for (int g = 0; g < ng; g++) mem[(base + g) % 256] = rand_vec();
      acc_q.delete();
      for (int i = 0; i < ng * np; i++) acc_q.push_back(rand_vec());
      run_cmd(base, ng, np, relu, 1, 0);
      build_expected(base, ng, np, relu);
      n_assert++;
      if (out_q.size() != exp_q.size() || rd_q.size() != ng) begin
        n_fail++; $display("FAIL rand%0d_count: outs=%0d reads=%0d expected %0d %0d",
                           it, out_q.size(), rd_q.size(), exp_q.size(), ng);
      end else begin
        for (int g = 0; g < ng; g++) begin
          n_assert++;
          if (rd_q[g] != (base + g) % 256) begin
            n_fail++; $display("FAIL rand%0d_addr%0d: got %0d expected %0d", it, g, rd_q[g], (base + g) % 256);
          end
        end
        foreach (exp_q[i]) begin
          n_assert++;
          if (out_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand%0d_out%0d: got %h expected %h", it, i, out_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multigroup_wrap();
    test_saturation();
    test_backpressure();
    test_degenerate();
    test_reset_mid_run();
    test_random();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
